// File: rtl/stream_pkg.sv
// Shared definitions for the stream demultiplexer: drop-counter width,
// the implicit hold state and a constant-elaboration clog2 helper.
package stream_pkg;

    localparam int unsigned DROP_CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } demux_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_demux.sv
// One-beat stream demultiplexer: routes a beat to one channel or broadcasts it
// to all, holding it until every targeted channel has taken it.
module stream_demux
    import stream_pkg::*;
#(
    parameter  int unsigned N_OUT  = 4,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned SEL_W  = clog2(N_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    output logic [N_OUT-1:0]      out_valid,
    input  logic [N_OUT-1:0]      out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  drop_err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [SEL_W:0] N_OUT_L = N_OUT[SEL_W:0];

    logic [N_OUT-1:0]      mask_q, mask_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  drop_err_q, drop_err_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [N_OUT-1:0]      ch_done;
    logic [N_OUT-1:0]      sel_hot;
    logic                  drain_all;
    logic                  accept;
    logic                  sel_illegal;
    demux_state_e          state;

    // Per-channel handshake and one-hot decode of the destination select.
    for (genvar k = 0; k < N_OUT; k++) begin : g_ch
        assign ch_done[k] = mask_q[k] & out_ready[k];
        assign sel_hot[k] = (in_sel == SEL_W'(k));
    end

    // Always false when N_OUT is a power of two, since in_sel cannot exceed it.
    assign sel_illegal = ({1'b0, in_sel} >= N_OUT_L);

    assign state     = (mask_q == '0) ? ST_IDLE : ST_HOLD;
    assign drain_all = ((mask_q & ~out_ready) == '0);
    assign in_ready  = rst_n & ((state == ST_IDLE) | drain_all);
    assign accept    = in_valid & in_ready;

    always_comb begin
        mask_d     = mask_q & ~ch_done;
        data_d     = data_q;
        drop_err_d = 1'b0;
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            if (in_bcast) begin
                mask_d = '1;
                data_d = in_data;
            end else if (sel_illegal) begin
                mask_d     = '0;
                drop_err_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
                end
            end else begin
                mask_d = sel_hot;
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '0;
            data_q     <= '0;
            drop_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            mask_q     <= mask_d;
            data_q     <= data_d;
            drop_err_q <= drop_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_valid = mask_q;
    assign out_data  = data_q;
    assign drop_err  = drop_err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
